// File: rtl/k10_trace_ctrl.sv
// Retire/trap trace capture: filters WB retire and trap-entry events while tracing is
// running and queues them as records in a small FIFO toward a ready/valid trace sink.
module k10_trace_ctrl #(
  parameter int          DEPTH = 4,
  parameter logic [31:0] PC_LO = 32'h0000_0000,
  parameter logic [31:0] PC_HI = 32'hFFFF_FFFF
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_cfg_en,
  input  logic                       i_ret_valid,
  input  logic [31:0]                i_ret_pc,
  input  logic [31:0]                i_ret_instr,
  input  logic [4:0]                 i_ret_rd_addr,
  input  logic [31:0]                i_ret_rd_data,
  input  logic                       i_ret_rd_wr_en,
  input  logic [1:0]                 i_ret_mode,
  input  logic                       i_trap_valid,
  input  logic [31:0]                i_trap_pc,
  input  logic [31:0]                i_trap_cause,
  output logic                       o_rec_valid,
  input  logic                       i_rec_ready,
  output logic                       o_rec_kind,
  output logic [31:0]                o_rec_pc,
  output logic [31:0]                o_rec_instr,
  output logic [4:0]                 o_rec_rd,
  output logic [31:0]                o_rec_data,
  output logic [1:0]                 o_rec_mode,
  output logic [15:0]                o_drop_cnt,
  output logic [$clog2(DEPTH):0]     o_occupancy,
  output logic [1:0]                 o_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = 104;
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);
  localparam logic [AW+1:0] TWO_W   = (AW+2)'(2);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t        state;
  logic [RW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [15:0]   drop_cnt;

  logic [32:0]   lo_diff;
  logic [32:0]   hi_diff;
  logic          in_win;
  logic          ret_q;
  logic          trap_q;
  logic          pop;
  logic          st_ret;
  logic          st_trap;
  logic [AW+1:0] free;
  logic [1:0]    n_push;
  logic [1:0]    n_drop;
  logic [AW:0]   count_nxt;
  logic [RW-1:0] ret_rec;
  logic [RW-1:0] trap_rec;
  logic [RW-1:0] head;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_comb begin
    // 33-bit differences give an unsigned window test whose borrow bit flags out-of-range
    lo_diff   = {1'b0, i_ret_pc} - {1'b0, PC_LO};
    hi_diff   = {1'b0, PC_HI} - {1'b0, i_ret_pc};
    in_win    = ~lo_diff[32] & ~hi_diff[32];
    ret_q     = (state == RUN) & i_ret_valid & i_ret_rd_wr_en &
                (i_ret_rd_addr != 5'd0) & in_win;
    trap_q    = (state == RUN) & i_trap_valid;
    pop       = (count != '0) & i_rec_ready;
    free      = DEPTH_W - {1'b0, count} + {{(AW+1){1'b0}}, pop};
    st_ret    = ret_q & (free != '0);
    st_trap   = trap_q & (st_ret ? (free >= TWO_W) : (free != '0));
    n_push    = {1'b0, st_ret} + {1'b0, st_trap};
    n_drop    = ({1'b0, ret_q} + {1'b0, trap_q}) - n_push;
    count_nxt = count + (AW+1)'(n_push) - (AW+1)'(pop);
    ret_rec   = {1'b0, i_ret_pc, i_ret_instr, i_ret_rd_addr, i_ret_rd_data, i_ret_mode};
    trap_rec  = {1'b1, i_trap_pc, 32'd0, 5'd0, i_trap_cause, 2'd3};
    head      = (count != '0) ? mem[rd_ptr] : '0;
  end

  // Retire takes the lower slot so it drains ahead of a same-cycle trap
  always_ff @(posedge i_clk) begin
    if (st_ret) mem[wr_ptr] <= ret_rec;
    if (st_trap) mem[st_ret ? wr_ptr + AW'(1) : wr_ptr] <= trap_rec;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(n_push);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nxt;
      drop_cnt <= sat_add16(drop_cnt, n_drop);
      case (state)
        IDLE:    if (i_cfg_en) state <= RUN;
        RUN:     if (!i_cfg_en) state <= (count_nxt != '0) ? DRAIN : IDLE;
        DRAIN: begin
          if (i_cfg_en) state <= RUN;
          else if (count_nxt == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_rec_valid = (count != '0);
  assign o_rec_kind  = head[103];
  assign o_rec_pc    = head[102:71];
  assign o_rec_instr = head[70:39];
  assign o_rec_rd    = head[38:34];
  assign o_rec_data  = head[33:2];
  assign o_rec_mode  = head[1:0];
  assign o_drop_cnt  = drop_cnt;
  assign o_occupancy = count;
  assign o_state     = state;

endmodule

// File: tb/tb_k10_trace_ctrl.sv
// Bench for k10_trace_ctrl: directed scenarios pinned with literal values, then random
// traffic checked every cycle against a queue-based model of the trace FIFO.
module tb_k10_trace_ctrl;

  localparam int          DEPTH = 4;
  localparam logic [31:0] LO    = 32'h8000_0000;
  localparam logic [31:0] HI    = 32'h8FFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, cfg_en;
  logic        ret_valid, ret_wr;
  logic [31:0] ret_pc, ret_instr, ret_data;
  logic [4:0]  ret_rd;
  logic [1:0]  ret_mode;
  logic        trap_valid;
  logic [31:0] trap_pc, trap_cause;
  logic        rec_ready;
  logic        rec_valid, rec_kind;
  logic [31:0] rec_pc, rec_instr, rec_data;
  logic [4:0]  rec_rd;
  logic [1:0]  rec_mode;
  logic [15:0] drop_cnt;
  logic [2:0]  occupancy;
  logic [1:0]  state;

  k10_trace_ctrl #(.DEPTH(DEPTH), .PC_LO(LO), .PC_HI(HI)) dut (
    .i_clk(clk), .i_rst(rst), .i_cfg_en(cfg_en),
    .i_ret_valid(ret_valid), .i_ret_pc(ret_pc), .i_ret_instr(ret_instr),
    .i_ret_rd_addr(ret_rd), .i_ret_rd_data(ret_data), .i_ret_rd_wr_en(ret_wr),
    .i_ret_mode(ret_mode), .i_trap_valid(trap_valid), .i_trap_pc(trap_pc),
    .i_trap_cause(trap_cause), .o_rec_valid(rec_valid), .i_rec_ready(rec_ready),
    .o_rec_kind(rec_kind), .o_rec_pc(rec_pc), .o_rec_instr(rec_instr),
    .o_rec_rd(rec_rd), .o_rec_data(rec_data), .o_rec_mode(rec_mode),
    .o_drop_cnt(drop_cnt), .o_occupancy(occupancy), .o_state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  mode;
  } rec_t;

  rec_t mq[$];
  int   mstate;
  int   mdrop;
  int   vectors = 0;
  int   errors  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: pop first, then fill free slots retire-first; anything left over is a drop.
  task automatic model_update();
    int   free;
    bit   cap, rq, tq;
    rec_t r;
    if (rst) begin
      mq.delete();
      mstate = 0;
      mdrop  = 0;
    end else begin
      cap  = (mstate == 1);
      rq   = cap && ret_valid && ret_wr && (ret_rd != 5'd0) && (ret_pc >= LO) && (ret_pc <= HI);
      tq   = cap && trap_valid;
      free = DEPTH - mq.size();
      if (mq.size() > 0 && rec_ready) begin
        void'(mq.pop_front());
        free++;
      end
      if (rq) begin
        if (free > 0) begin
          r.kind = 1'b0; r.pc = ret_pc; r.instr = ret_instr;
          r.rd = ret_rd; r.data = ret_data; r.mode = ret_mode;
          mq.push_back(r);
          free--;
        end else mdrop++;
      end
      if (tq) begin
        if (free > 0) begin
          r.kind = 1'b1; r.pc = trap_pc; r.instr = 32'd0;
          r.rd = 5'd0; r.data = trap_cause; r.mode = 2'd3;
          mq.push_back(r);
          free--;
        end else mdrop++;
      end
      if (mdrop > 65535) mdrop = 65535;
      case (mstate)
        0: if (cfg_en) mstate = 1;
        1: if (!cfg_en) mstate = (mq.size() > 0) ? 2 : 0;
        default: begin
          if (cfg_en) mstate = 1;
          else if (mq.size() == 0) mstate = 0;
        end
      endcase
    end
  endtask

  task automatic compare_all();
    chk("valid", 32'(rec_valid), 32'(mq.size() > 0));
    chk("occupancy", 32'(occupancy), 32'(mq.size()));
    chk("drop_cnt", 32'(drop_cnt), 32'(mdrop));
    chk("state", 32'(state), 32'(mstate));
    if (mq.size() > 0) begin
      chk("kind", 32'(rec_kind), 32'(mq[0].kind));
      chk("pc", rec_pc, mq[0].pc);
      chk("instr", rec_instr, mq[0].instr);
      chk("rd", 32'(rec_rd), 32'(mq[0].rd));
      chk("data", rec_data, mq[0].data);
      chk("mode", 32'(rec_mode), 32'(mq[0].mode));
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic clear_events();
    ret_valid = 0; ret_wr = 0; ret_pc = 0; ret_instr = 0; ret_rd = 0;
    ret_data = 0; ret_mode = 0; trap_valid = 0; trap_pc = 0; trap_cause = 0;
  endtask

  task automatic set_retire(input logic [31:0] pc, input logic [4:0] rd,
                            input logic [31:0] data, input logic wr);
    ret_valid = 1; ret_wr = wr; ret_pc = pc; ret_rd = rd; ret_data = data;
    ret_instr = 32'h0000_0013 ^ pc; ret_mode = 2'd0;
  endtask

  int ready_pct;

  initial begin
    rst = 1; cfg_en = 0; rec_ready = 0;
    clear_events();
    step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);

    // Basic retire with one-cycle latency
    rst = 0; cfg_en = 1;
    step();
    chk("run_state", 32'(state), 32'd1);
    rec_ready = 1;
    set_retire(32'h8000_0000, 5'd10, 32'h1234, 1'b1);
    step();
    chk("t1_valid", 32'(rec_valid), 32'd1);
    chk("t1_kind", 32'(rec_kind), 32'd0);
    chk("t1_pc", rec_pc, 32'h8000_0000);
    chk("t1_rd", 32'(rec_rd), 32'd10);
    chk("t1_data", rec_data, 32'h1234);
    chk("t1_occ", 32'(occupancy), 32'd1);
    clear_events();
    step();
    chk("t1_occ_after", 32'(occupancy), 32'd0);

    // Same-cycle retire and trap
    set_retire(32'h8000_0010, 5'd5, 32'hAAAA, 1'b1);
    trap_valid = 1; trap_pc = 32'h0000_0100; trap_cause = 32'hB;
    step();
    chk("t2_first_kind", 32'(rec_kind), 32'd0);
    chk("t2_first_pc", rec_pc, 32'h8000_0010);
    clear_events();
    step();
    chk("t2_trap_kind", 32'(rec_kind), 32'd1);
    chk("t2_trap_mode", 32'(rec_mode), 32'd3);
    chk("t2_trap_data", rec_data, 32'hB);
    chk("t2_trap_instr", rec_instr, 32'd0);
    chk("t2_drop", 32'(drop_cnt), 32'd0);
    step();

    // Filtered retires, then the inclusive upper bound
    set_retire(32'h8000_0020, 5'd0, 32'h1, 1'b1); step();
    set_retire(32'h8000_0020, 5'd3, 32'h1, 1'b0); step();
    set_retire(32'h7FFF_FFFC, 5'd3, 32'h1, 1'b1); step();
    set_retire(32'h9000_0000, 5'd3, 32'h1, 1'b1); step();
    chk("t4_occ", 32'(occupancy), 32'd0);
    chk("t4_drop", 32'(drop_cnt), 32'd0);
    set_retire(32'h8FFF_FFFF, 5'd3, 32'h77, 1'b1); step();
    chk("t4_hi_pc", rec_pc, 32'h8FFF_FFFF);
    clear_events(); step();

    // Overflow: 6 retires into a 4-deep FIFO with the sink stalled, then 3 more
    rec_ready = 0;
    for (int i = 0; i < 9; i++) begin
      set_retire(32'h8000_0000 + 32'(i * 4), 5'd1, 32'(i), 1'b1);
      step();
      if (i == 5) begin
        chk("t3_occ", 32'(occupancy), 32'd4);
        chk("t3_drop", 32'(drop_cnt), 32'd2);
        chk("t3_head", rec_pc, 32'h8000_0000);
      end
    end
    chk("t6_drop5", 32'(drop_cnt), 32'd5);

    // Reset while full, with events present in the reset cycle
    rst = 1; trap_valid = 1; rec_ready = 1;
    step();
    chk("t6_valid", 32'(rec_valid), 32'd0);
    chk("t6_occ", 32'(occupancy), 32'd0);
    chk("t6_drop", 32'(drop_cnt), 32'd0);
    chk("t6_state", 32'(state), 32'd0);
    chk("t6_pc", rec_pc, 32'd0);
    chk("t6_kind", 32'(rec_kind), 32'd0);
    chk("t6_data", rec_data, 32'd0);
    chk("t6_mode", 32'(rec_mode), 32'd0);

    // Drain: 3 entries queued, enable drops, events during DRAIN are ignored
    rst = 0; rec_ready = 0; clear_events();
    step();
    for (int i = 0; i < 3; i++) begin
      set_retire(32'h8000_1000 + 32'(i * 4), 5'd2, 32'(i), 1'b1);
      step();
    end
    clear_events(); cfg_en = 0;
    step();
    chk("t5_drain", 32'(state), 32'd2);
    chk("t5_occ3", 32'(occupancy), 32'd3);
    rec_ready = 1;
    set_retire(32'h8000_2000, 5'd4, 32'h9, 1'b1);
    trap_valid = 1; trap_cause = 32'h2;
    step();
    chk("t5_head2", rec_pc, 32'h8000_1004);
    step();
    step();
    chk("t5_idle", 32'(state), 32'd0);
    chk("t5_occ0", 32'(occupancy), 32'd0);
    chk("t5_drop0", 32'(drop_cnt), 32'd0);

    // Random traffic
    clear_events(); cfg_en = 1; ready_pct = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) ready_pct = (n % 1500 == 0) ? 20 : ((n % 1000 == 0) ? 90 : 50);
      rst       = ($urandom % 150) == 0;
      if (($urandom % 16) == 0) cfg_en = ~cfg_en;
      ret_valid = ($urandom % 2) == 0;
      ret_wr    = ($urandom % 5) != 0;
      ret_rd    = (($urandom % 8) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      case ($urandom % 4)
        0:       ret_pc = $urandom;
        1:       ret_pc = LO + 32'(($urandom % 16) * 4);
        2:       ret_pc = HI - 32'($urandom % 16);
        default: ret_pc = (($urandom % 2) == 0) ? LO - 32'd1 : HI + 32'd1;
      endcase
      ret_instr  = $urandom;
      ret_data   = $urandom;
      ret_mode   = 2'($urandom % 4);
      trap_valid = ($urandom % 10) < 3;
      trap_pc    = $urandom;
      trap_cause = $urandom;
      rec_ready  = 32'($urandom % 100) < 32'(ready_pct);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/k10_trace_ctrl.md
K10_TRACE_CTRL -- requirements
Module: k10_trace_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, record FIFO depth (power of 2, >=2).
REQ-002 SHALL have parameter PC_LO, default 32'h0000_0000, inclusive lower bound of the retire capture window.
REQ-003 SHALL have parameter PC_HI, default 32'hFFFF_FFFF, inclusive upper bound of the retire capture window.
REQ-004 SHALL have ports: i_clk  in  1  clock; one clock domain, all logic on posedge.
REQ-005 i_rst  in  1  reset; synchronous, active-high.
REQ-006 i_cfg_en  in  1  tracing enable.
REQ-007 i_ret_valid in 1, i_ret_pc in 32, i_ret_instr in 32, i_ret_rd_addr in 5, i_ret_rd_data in 32, i_ret_rd_wr_en in 1, i_ret_mode in 2: WB retire event.
REQ-008 i_trap_valid in 1, i_trap_pc in 32, i_trap_cause in 32: trap-entry event.
REQ-009 o_rec_valid out 1, i_rec_ready in 1: record handshake to the trace sink.
REQ-010 o_rec_kind out 1 (0 retire, 1 trap), o_rec_pc out 32, o_rec_instr out 32 (0 for trap), o_rec_rd out 5 (0 for trap), o_rec_data out 32 (rd data or cause), o_rec_mode out 2 (3 for trap).
REQ-011 o_drop_cnt out 16: saturating count of lost events.
REQ-012 o_occupancy out $clog2(DEPTH)+1: FIFO entry count.
REQ-013 o_state out 2: FSM state (0 IDLE, 1 RUN, 2 DRAIN).

Function
REQ-014 FSM SHALL be: IDLE -> RUN when i_cfg_en=1; RUN -> DRAIN when i_cfg_en=0 and FIFO non-empty; RUN -> IDLE when i_cfg_en=0 and FIFO empty; DRAIN -> IDLE when FIFO becomes empty; DRAIN -> RUN when i_cfg_en=1.
REQ-015 Events SHALL be captured only in RUN, including the cycle i_cfg_en deasserts; never in IDLE or DRAIN.
REQ-016 A retire event SHALL qualify only if i_ret_valid=1, i_ret_rd_wr_en=1, i_ret_rd_addr!=0 and PC_LO<=i_ret_pc<=PC_HI (unsigned).
REQ-017 A trap event SHALL qualify whenever i_trap_valid=1, with no PC filtering.
REQ-018 Up to two records SHALL be pushed per cycle; when both qualify, retire SHALL occupy the lower FIFO slot, so it is emitted before the trap.
REQ-019 Free slots SHALL be DEPTH minus the start-of-cycle occupancy plus 1 if a pop occurs that cycle (o_rec_valid and i_rec_ready).
REQ-020 If free slots < qualifying events, retire SHALL win the single slot; each unstored event SHALL increment o_drop_cnt by 1, and the count SHALL saturate at 16'hFFFF.
REQ-021 o_rec_valid SHALL equal FIFO non-empty; o_rec_* SHALL present the head entry and SHALL stay stable while o_rec_valid=1 and i_rec_ready=0.
REQ-022 Latency: an event captured in cycle N into an empty FIFO SHALL appear on o_rec_* in cycle N+1.
REQ-023 A pop SHALL occur exactly when o_rec_valid=1 and i_rec_ready=1.
REQ-024 o_occupancy SHALL equal pushes minus pops since reset and SHALL never exceed DEPTH.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH without loss.
REQ-026 i_rec_ready SHALL be ignored when the FIFO is empty.

Reset
REQ-027 With i_rst=1 at a posedge, the FIFO SHALL be emptied, state SHALL become IDLE, and o_drop_cnt and o_occupancy SHALL clear to 0.
REQ-028 During reset, o_rec_valid, o_rec_kind, o_rec_pc, o_rec_instr, o_rec_rd, o_rec_data and o_rec_mode SHALL be 0 on the next cycle.
REQ-029 A reset asserted mid-operation SHALL discard all pending records and events captured in that cycle.

Verification
REQ-030 en=1, retire pc=0x80000000 rd=a0(10) data=0x1234 wr_en=1, ready=1 -> next cycle o_rec_valid=1, kind=0, pc=0x80000000, rd=10, data=0x1234; occupancy=1 then 0.
REQ-031 Same-cycle qualifying retire and trap (cause=0xB) into empty FIFO, ready=1 -> retire record, then trap record (mode=3, data=0xB) on consecutive cycles; drop_cnt=0.
REQ-032 DEPTH=4, ready=0, 6 qualifying retires -> occupancy=4, drop_cnt=2, head pc = first retire's pc.
REQ-033 Retire with rd=0, wr_en=0, or pc outside [PC_LO,PC_HI] -> no push, drop_cnt unchanged.
REQ-034 FIFO holds 3 entries, en drops to 0 -> state DRAIN, 3 records emitted, then IDLE; events arriving during DRAIN are ignored.
REQ-035 Reset while FIFO full and drop_cnt=5 -> next cycle o_rec_valid=0, occupancy=0, drop_cnt=0, state IDLE.
